// File: rtl/jt49_mix_pkg.sv
// Shared types and constants for the jt49 stereo mixer / DC-removal stage.
package jt49_mix_pkg;

   typedef enum logic [3:0] {
      IDLE,
      MUL0,
      MUL1,
      MUL2,
      MUL3,
      MUL4,
      MUL5,
      DC,
      OUT
   } state_t;

   // Accumulator width: 3 * 255 * 255 = 195075 fits in 18 bits unsigned.
   localparam int ACCW = 18;
   // Filter input width: acc >> 2, max 48768.
   localparam int XW   = 16;

   // Mid-scale offset subtracted when the DC filter is bypassed.
   localparam logic [XW-1:0] BYP_OFS = 16'h8000;

   localparam logic signed [16:0] SAT_MAX = 17'sd32767;
   localparam logic signed [16:0] SAT_MIN = -17'sd32768;

   // Clamp a 17-bit signed difference into a 16-bit signed sample.
   function automatic logic [15:0] sat16(input logic signed [16:0] v);
      logic [15:0] r;
      if (v > SAT_MAX)
         r = 16'h7FFF;
      else if (v < SAT_MIN)
         r = 16'h8000;
      else
         r = v[15:0];
      return r;
   endfunction

endpackage

// File: rtl/jt49_mix_if.sv
// Sample strobe, channel levels, gains and stereo result of the mixer.
interface jt49_mix_if;
   import jt49_mix_pkg::*;

   logic        cen;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [7:0]  C;
   logic [23:0] gain_l;
   logic [23:0] gain_r;
   logic        dc_en;
   logic [15:0] left;
   logic [15:0] right;
   logic        sample;
   logic        busy;
   logic        ovr;

   // Upstream side: PSG core / controller driving levels and gains.
   modport master (
      output cen, A, B, C, gain_l, gain_r, dc_en,
      input  left, right, sample, busy, ovr
   );

   // Mixer side.
   modport slave (
      input  cen, A, B, C, gain_l, gain_r, dc_en,
      output left, right, sample, busy, ovr
   );
endinterface

// File: rtl/jt49_mix_dcrm.sv
// First-order DC-removal high-pass (pole 1 - 2^-DCK) with bypass offset and saturation.
module jt49_dcrm
   import jt49_mix_pkg::*;
#(
   parameter int DCK = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          byp,
   input  logic [XW-1:0] x,
   output logic [15:0]   y
);

   localparam int AW = XW + DCK;

   logic [AW-1:0]     dcacc_q;
   logic [AW-1:0]     dcacc_d;
   logic [XW-1:0]     fb;
   logic signed [16:0] diff;
   logic [15:0]       y_q;

   // Feedback term is the integrator scaled down by the pole shift.
   assign fb = dcacc_q[AW-1:DCK];

   // Output uses the pre-update integrator; bypass subtracts a fixed mid-scale offset.
   always_comb begin
      if (byp)
         diff = $signed({1'b0, x}) - $signed({1'b0, BYP_OFS});
      else
         diff = $signed({1'b0, x}) - $signed({1'b0, fb});
      dcacc_d = dcacc_q - AW'(fb) + AW'(x);
   end

   // Update integrator and latch saturated sample on each strobe; integrator frozen in bypass.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcacc_q <= '0;
         y_q     <= '0;
      end else if (en) begin
         y_q <= sat16(diff);
         if (!byp)
            dcacc_q <= dcacc_d;
      end
   end

   assign y = y_q;

endmodule

// File: rtl/jt49_mix.sv
// Stereo gain mixer: time-shared 8x8 multiplier over six steps, then DC filter per side.
module jt49_mix
   import jt49_mix_pkg::*;
#(
   parameter int DCK = 10
) (
   input  logic       clk,
   input  logic       rst,
   jt49_mix_if.slave  bus
);

   state_t            state_q, state_d;
   logic [7:0]        a_q, b_q, c_q;
   logic [23:0]       gl_q, gr_q;
   logic              dcen_q;
   logic [ACCW-1:0]   acc_l_q, acc_r_q;
   logic [15:0]       left_q, right_q;
   logic              sample_q, ovr_q;

   logic [7:0]        mul_x, mul_g;
   logic [15:0]       prod;
   logic              sel_l, sel_r;
   logic              dc_upd;
   logic [XW-1:0]     x_l, x_r;
   logic [15:0]       y_l, y_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state: fixed walk through the six products, filter, output.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.cen) state_d = MUL0;
         MUL0:    state_d = MUL1;
         MUL1:    state_d = MUL2;
         MUL2:    state_d = MUL3;
         MUL3:    state_d = MUL4;
         MUL4:    state_d = MUL5;
         MUL5:    state_d = DC;
         DC:      state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state multiplier operand and accumulator selection, plus status outputs.
   always_comb begin
      mul_x  = '0;
      mul_g  = '0;
      sel_l  = 1'b0;
      sel_r  = 1'b0;
      case (state_q)
         MUL0: begin mul_x = a_q; mul_g = gl_q[7:0];   sel_l = 1'b1; end
         MUL1: begin mul_x = a_q; mul_g = gr_q[7:0];   sel_r = 1'b1; end
         MUL2: begin mul_x = b_q; mul_g = gl_q[15:8];  sel_l = 1'b1; end
         MUL3: begin mul_x = b_q; mul_g = gr_q[15:8];  sel_r = 1'b1; end
         MUL4: begin mul_x = c_q; mul_g = gl_q[23:16]; sel_l = 1'b1; end
         MUL5: begin mul_x = c_q; mul_g = gr_q[23:16]; sel_r = 1'b1; end
         default: ;
      endcase
      dc_upd = (state_q == DC);
   end

   assign prod = {8'd0, mul_x} * {8'd0, mul_g};
   assign x_l  = XW'(acc_l_q >> 2);
   assign x_r  = XW'(acc_r_q >> 2);

   // Input capture, accumulation, overrun detection and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         gl_q     <= '0;
         gr_q     <= '0;
         dcen_q   <= 1'b0;
         acc_l_q  <= '0;
         acc_r_q  <= '0;
         left_q   <= '0;
         right_q  <= '0;
         sample_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         sample_q <= 1'b0;
         ovr_q    <= 1'b0;
         if (bus.cen) begin
            if (state_q == IDLE) begin
               a_q     <= bus.A;
               b_q     <= bus.B;
               c_q     <= bus.C;
               gl_q    <= bus.gain_l;
               gr_q    <= bus.gain_r;
               dcen_q  <= bus.dc_en;
               acc_l_q <= '0;
               acc_r_q <= '0;
            end else begin
               ovr_q <= 1'b1;
            end
         end
         if (sel_l)
            acc_l_q <= acc_l_q + ACCW'(prod);
         if (sel_r)
            acc_r_q <= acc_r_q + ACCW'(prod);
         if (state_q == OUT) begin
            left_q   <= y_l;
            right_q  <= y_r;
            sample_q <= 1'b1;
         end
      end
   end

   jt49_dcrm #(.DCK(DCK)) u_dc_l (
      .clk (clk),
      .rst (rst),
      .en  (dc_upd),
      .byp (~dcen_q),
      .x   (x_l),
      .y   (y_l)
   );

   jt49_dcrm #(.DCK(DCK)) u_dc_r (
      .clk (clk),
      .rst (rst),
      .en  (dc_upd),
      .byp (~dcen_q),
      .x   (x_r),
      .y   (y_r)
   );

   assign bus.left   = left_q;
   assign bus.right  = right_q;
   assign bus.sample = sample_q;
   assign bus.ovr    = ovr_q;
   assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_jt49_mix.sv
// Directed bench for jt49_mix (DCK=4): bypass levels, reset abort, overrun, latching, DC settling.
module tb_jt49_mix;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   jt49_mix_if bus ();

   jt49_mix #(.DCK(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-14s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [23:0] gl, input logic [23:0] gr, input logic dc);
      bus.A      = a;
      bus.B      = b;
      bus.C      = c;
      bus.gain_l = gl;
      bus.gain_r = gr;
      bus.dc_en  = dc;
   endtask

   // Present cen for exactly one rising edge (edge 0).
   task automatic start();
      bus.cen = 1'b1;
      tick();
      bus.cen = 1'b0;
   endtask

   // Count edges until sample is seen; -1 if the bound expires.
   task automatic wait_sample(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.sample === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int cnt;
      int ovr_cnt;
      int smp_cnt;
      int cur;
      int prev;

      bus.cen = 1'b0;
      set_in(8'd0, 8'd0, 8'd0, 24'd0, 24'd0, 1'b0);
      tick();
      tick();

      // Reset state
      chk("rst_left",   $signed(bus.left), 0);
      chk("rst_right",  $signed(bus.right), 0);
      chk("rst_sample", {31'd0, bus.sample}, 0);
      chk("rst_busy",   {31'd0, bus.busy}, 0);
      chk("rst_ovr",    {31'd0, bus.ovr}, 0);
      rst = 1'b0;
      tick();

      // Bypass, channel A only on the left: 65025>>2 = 16256, minus 32768
      set_in(8'd255, 8'd0, 8'd0, 24'h0000FF, 24'h000000, 1'b0);
      start();
      chk("busy_on", {31'd0, bus.busy}, 1);
      wait_sample(lat);
      chk("byp_lat",   lat, 8);
      chk("byp_left",  $signed(bus.left), -16512);
      chk("byp_right", $signed(bus.right), -32768);
      tick();
      chk("smp_width", {31'd0, bus.sample}, 0);
      chk("busy_off",  {31'd0, bus.busy}, 0);
      chk("hold_left", $signed(bus.left), -16512);

      // Reset while in MUL3 aborts the sample
      set_in(8'd255, 8'd255, 8'd255, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
      start();
      tick();
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("abort_busy",  {31'd0, bus.busy}, 0);
      chk("abort_left",  $signed(bus.left), 0);
      chk("abort_right", $signed(bus.right), 0);
      cnt = 0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         cnt += int'(bus.sample);
      end
      chk("abort_nosmp", cnt, 0);

      // Full scale, no saturation: 195075>>2 = 48768, minus 32768
      start();
      wait_sample(lat);
      chk("full_lat",   lat, 8);
      chk("full_left",  $signed(bus.left), 16000);
      chk("full_right", $signed(bus.right), 16000);

      // Inputs changed during MUL2 must not affect the sample in flight
      set_in(8'd255, 8'd0, 8'd0, 24'h0000FF, 24'h000000, 1'b0);
      start();
      tick();
      tick();
      set_in(8'd255, 8'd255, 8'd255, 24'hFFFFFF, 24'hFFFFFF, 1'b1);
      wait_sample(lat);
      chk("latch_lat",   lat, 6);
      chk("latch_left",  $signed(bus.left), -16512);
      chk("latch_right", $signed(bus.right), -32768);

      // cen every 4 clocks at 0..20: accepted at 0 and 12; 4,8,16,20 dropped
      set_in(8'd255, 8'd255, 8'd255, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
      ovr_cnt = 0;
      smp_cnt = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         bus.cen = ((cyc % 4) == 0) && (cyc <= 20);
         tick();
         ovr_cnt += int'(bus.ovr);
         smp_cnt += int'(bus.sample);
      end
      bus.cen = 1'b0;
      chk("ovr_count",  ovr_cnt, 4);
      chk("smp_count",  smp_cnt, 2);
      chk("ovr_left",   $signed(bus.left), 16000);

      // DC filter from reset, DCK=4, constant A=255 on the left
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      set_in(8'd255, 8'd0, 8'd0, 24'h0000FF, 24'h000000, 1'b1);
      prev = 0;
      for (int k = 1; k <= 305; k++) begin
         start();
         wait_sample(lat);
         cur = $signed(bus.left);
         if (k == 1) begin
            chk("dc_lat",    lat, 8);
            chk("dc_first",  cur, 16256);
            chk("dc_right",  $signed(bus.right), 0);
         end else begin
            chk("dc_mono", (cur <= prev) ? 1 : 0, 1);
         end
         if (k == 2)
            chk("dc_second", cur, 15240);
         if (k >= 300)
            chk("dc_settled", cur, 0);
         prev = cur;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
